// File: rtl/seg7_reader_if.sv
// seg7_reader_if: segment pattern input, decoded digit handshake and status of the seven-segment reader.
interface seg7_reader_if #(parameter int DIGITS = 4);
  logic [6:0] leds;
  logic [3:0] bcd;
  logic out_valid;
  logic out_ready;
  logic err;
  logic overflow;
  logic [4*DIGITS-1:0] digits;
  logic [7:0] digit_count;
  modport master(output leds, out_ready, input bcd, out_valid, err, overflow, digits, digit_count);
  modport slave(input leds, out_ready, output bcd, out_valid, err, overflow, digits, digit_count);
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: debounces an active-low seven-segment pattern and decodes stable digits with a valid/ready output and history.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic reset,
  seg7_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} state_t;
  localparam logic [7:0] S = 8'(STABLE_CYCLES);
  state_t state, state_n;
  logic [6:0] prev;
  logic [7:0] run, run_n;
  logic changed, decide, is_blank, is_digit;
  logic [3:0] dec;
  logic [4*DIGITS-1:0] dec_ext;
  assign changed = bus.leds != prev;
  assign run_n = changed ? 8'd1 : (run >= S ? S : run + 8'd1);
  assign is_blank = bus.leds == 7'b1111111;
  assign dec_ext = (4*DIGITS)'(dec);
  always_comb begin
    dec = 4'd0;
    is_digit = 1'b1;
    case (bus.leds)
      7'b1000000: dec = 4'd0;
      7'b1111001: dec = 4'd1;
      7'b0100100: dec = 4'd2;
      7'b0110000: dec = 4'd3;
      7'b0011001: dec = 4'd4;
      7'b0010010: dec = 4'd5;
      7'b0000010: dec = 4'd6;
      7'b1111000: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0010000: dec = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end
  // The decision edge is the one where the held run reaches its full length.
  always_comb begin
    state_n = state;
    decide = 1'b0;
    case (state)
      IDLE: state_n = changed ? SETTLING : IDLE;
      SETTLING: begin
        decide = !changed && run_n == S;
        state_n = decide ? (is_blank ? IDLE : LOCKED) : SETTLING;
      end
      LOCKED: state_n = changed ? SETTLING : LOCKED;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev <= 7'b1111111;
      run <= 8'd0;
      bus.bcd <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
      bus.overflow <= 1'b0;
      bus.digits <= '0;
      bus.digit_count <= 8'd0;
    end else begin
      prev <= bus.leds;
      run <= run_n;
      bus.err <= decide && !is_digit && !is_blank;
      if (decide && is_digit) begin
        bus.bcd <= dec;
        bus.out_valid <= 1'b1;
        bus.digits <= (bus.digits << 4) | dec_ext;
        bus.digit_count <= bus.digit_count == 8'd255 ? bus.digit_count : bus.digit_count + 8'd1;
        if (bus.out_valid && !bus.out_ready) bus.overflow <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: table-driven directed checks of seg7_reader plus handshake and async-reset sequences.
module tb_seg7_reader;
  typedef struct {
    logic [6:0] leds;
    logic ready;
    int n;
    logic [3:0] bcd;
    logic v;
    logic e;
    logic o;
    logic [15:0] dig;
    logic [7:0] cnt;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tbl[17];
  seg7_reader_if #(.DIGITS(4)) bus();
  seg7_reader #(.STABLE_CYCLES(4), .DIGITS(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic [6:0] l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      bus.leds = l;
      bus.out_ready = r;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check(input string name, input logic [3:0] b, input logic v, input logic e,
                       input logic o, input logic [15:0] d, input logic [7:0] c);
    cmp({name, ".bcd"}, 16'(bus.bcd), 16'(b));
    cmp({name, ".out_valid"}, 16'(bus.out_valid), 16'(v));
    cmp({name, ".err"}, 16'(bus.err), 16'(e));
    cmp({name, ".overflow"}, 16'(bus.overflow), 16'(o));
    cmp({name, ".digits"}, bus.digits, d);
    cmp({name, ".digit_count"}, 16'(bus.digit_count), 16'(c));
  endtask
  initial begin
    tbl[0]  = '{7'h7f, 1'b1, 2, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0};
    tbl[1]  = '{7'h30, 1'b1, 3, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0};
    tbl[2]  = '{7'h30, 1'b1, 1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[3]  = '{7'h30, 1'b1, 1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[4]  = '{7'h30, 1'b1, 3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[5]  = '{7'h7f, 1'b1, 4, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[6]  = '{7'h30, 1'b1, 3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[7]  = '{7'h7f, 1'b1, 4, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 8'd1};
    tbl[8]  = '{7'h12, 1'b1, 4, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0035, 8'd2};
    tbl[9]  = '{7'h7f, 1'b1, 4, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0035, 8'd2};
    tbl[10] = '{7'h12, 1'b1, 4, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0355, 8'd3};
    tbl[11] = '{7'h7e, 1'b1, 4, 4'd5, 1'b0, 1'b1, 1'b0, 16'h0355, 8'd3};
    tbl[12] = '{7'h7e, 1'b1, 1, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0355, 8'd3};
    tbl[13] = '{7'h78, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 16'h3557, 8'd4};
    tbl[14] = '{7'h7f, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 16'h3557, 8'd4};
    tbl[15] = '{7'h10, 1'b0, 4, 4'd9, 1'b1, 1'b0, 1'b1, 16'h5579, 8'd5};
    tbl[16] = '{7'h7f, 1'b1, 1, 4'd9, 1'b0, 1'b0, 1'b1, 16'h5579, 8'd5};
    bus.leds = 7'h7f;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].leds, tbl[i].ready, tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].v, tbl[i].e, tbl[i].o, tbl[i].dig, tbl[i].cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(7'h24, 1'b0, 4);
    check("hs_two", 4'd2, 1'b1, 1'b0, 1'b0, 16'h0002, 8'd1);
    drive(7'h19, 1'b0, 3);
    drive(7'h19, 1'b1, 1);
    check("hs_same_edge", 4'd4, 1'b1, 1'b0, 1'b0, 16'h0024, 8'd2);
    drive(7'h02, 1'b1, 4);
    drive(7'h00, 1'b1, 4);
    drive(7'h79, 1'b1, 4);
    check("history", 4'd1, 1'b1, 1'b0, 1'b0, 16'h4681, 8'd5);
    drive(7'h78, 1'b1, 2);
    #2 reset = 1'b1;
    #1 check("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(7'h78, 1'b1, 3);
    check("post_reset_run", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    drive(7'h78, 1'b1, 1);
    check("post_reset_decode", 4'd7, 1'b1, 1'b0, 1'b0, 16'h0007, 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
